// File: rtl/sr_pkg.sv
// Shared encodings for the SR-flop excitation sequencer: S/R drive codes and FSM states.
package sr_pkg;

  localparam logic [1:0] SR_HOLD    = 2'b00;
  localparam logic [1:0] SR_RESET   = 2'b01;
  localparam logic [1:0] SR_SET     = 2'b10;
  localparam logic [1:0] SR_INVALID = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2
  } state_t;

endpackage

// File: rtl/sr_excite.sv
// SR flip-flop excitation table: current Q and target bit t give the S/R pair.
module sr_excite
  import sr_pkg::*;
(
  input  logic       q,
  input  logic       t,
  output logic [1:0] sr
);

  always_comb begin
    sr = SR_HOLD;
    if (!q && t) begin
      sr = SR_SET;
    end else if (q && !t) begin
      sr = SR_RESET;
    end
  end

endmodule

// File: rtl/sr_excite_seq.sv
// Walks a target pattern LSB first onto an external SR flop, two clocks per bit,
// and checks the fed-back Q after every transition.
module sr_excite_seq
  import sr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4,
  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic             q_fb,
  output logic             ready,
  output logic [1:0]       sr,
  output logic [IDX_W-1:0] bit_idx,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic             err,
  output logic             done
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] shreg_shifted;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             done_q, done_d;
  logic [1:0]       sr_q, sr_d;
  logic             next_t;
  logic [1:0]       excite_sr;

  // The shift register keeps the current target in bit 0, so the bit for the
  // next DRIVE is bit 1 (or pattern bit 0 when a word is being accepted).
  assign shreg_shifted = shreg_q >> 1;
  assign next_t        = (state_q == IDLE) ? pattern[0] : shreg_shifted[0];

  sr_excite u_excite (
    .q  (q_fb),
    .t  (next_t),
    .sr (excite_sr)
  );

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    done_d  = 1'b0;
    sr_d    = SR_HOLD;
    case (state_q)
      IDLE: begin
        if (start) begin
          shreg_d = pattern;
          idx_d   = '0;
          sr_d    = excite_sr;
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        state_d = CHECK;
      end
      CHECK: begin
        if (q_fb != shreg_q[0]) begin
          err_d = 1'b1;
          if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        if (idx_q == LAST_IDX) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          shreg_d = shreg_shifted;
          sr_d    = excite_sr;
          state_d = DRIVE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      shreg_q <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      sr_q    <= SR_HOLD;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      done_q  <= done_d;
      sr_q    <= sr_d;
    end
  end

  assign ready        = (state_q == IDLE);
  assign sr           = sr_q;
  assign bit_idx      = idx_q;
  assign mismatch_cnt = cnt_q;
  assign err          = err_q;
  assign done         = done_q;

endmodule
